// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetch into a DEPTH-entry FIFO feeding IF/ID.
// Optional macro PREFETCH_BYPASS_EN forwards an ack to decode when the FIFO is empty.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = $clog2(DEPTH+1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Redirect,
  input  logic [31:0]   RedirectPC,
  input  logic          Take,
  output logic          MemReq,
  output logic [31:0]   MemAddr,
  input  logic          MemAck,
  input  logic [31:0]   MemData,
  output logic          InstValid,
  output logic [31:0]   Instruction,
  output logic [31:0]   NextAddress,
  output logic [31:0]   FetchPC,
  output logic [CW-1:0] Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_e;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_after;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          ack;
  logic          fifo_vld;
  logic          pop;
  logic          push;
  logic          byp;
  logic [31:0]   head_pc;

  assign ack      = MemAck & req_q;
  assign fifo_vld = (cnt_q != '0);
  assign pop      = Take & fifo_vld;

`ifdef PREFETCH_BYPASS_EN
  assign byp = ~fifo_vld & ack & ~Redirect
             & (state_q == S_WAIT);
`else
  assign byp = 1'b0;
`endif

  // a bypassed word taken by decode never enters the FIFO
  assign push = ack & ~Redirect
              & (state_q == S_WAIT)
              & ~(byp & Take);

  assign cnt_after = cnt_q - CW'(pop);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (!Redirect && cnt_after < FULL) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack) begin
          req_d   = 1'b0;
          pc_d    = pc_q + 32'd4;
          state_d = S_IDLE;
        end else if (Redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Redirect) begin
      pc_d = {RedirectPC[31:2], 2'b00};
    end
  end

  always_comb begin
    if (Redirect) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_after + CW'(push);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      data_mem[wr_q] <= MemData;
      pc_mem[wr_q]   <= addr_q;
    end
  end

  always_comb begin
    InstValid   = fifo_vld;
    Instruction = fifo_vld ? data_mem[rd_q] : '0;
    head_pc     = fifo_vld ? pc_mem[rd_q] : '0;
    if (byp) begin
      InstValid   = 1'b1;
      Instruction = MemData;
      head_pc     = addr_q;
    end
    FetchPC     = head_pc;
    NextAddress = InstValid ? head_pc + 32'd4 : '0;
  end

  assign MemReq  = req_q;
  assign MemAddr = addr_q;
  assign Count   = cnt_q;

endmodule
